// File: rtl/wr_dec_sequencer_pkg.sv
// Shared constants and request record for the register-write sequencer.
// Default sizes match the processor's 20-register block with an 8-bit data bus.
package wr_seq_pkg;

    localparam int NUM_REGS_DEF = 20;
    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 8;
    localparam int DEPTH_DEF    = 4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_req_t;

    // Occupancy counter width: one extra bit so a full FIFO is distinguishable from empty.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wr_dec_sequencer_if.sv
// Valid/ready request channel from the control unit into the write sequencer.
interface wr_dec_sequencer_if
    import wr_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/wr_dec_sequencer_fifo.sv
// Small synchronous FIFO holding pending register writes; head is read combinationally
// so the issue stage can register the strobe in the same edge as the pop.
module wr_req_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic               pop_i,
    output logic [WIDTH-1:0]   rdata_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Guard against overflow/underflow even if the caller ignores full/empty.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wr_dec_sequencer.sv
// Write-side sequencer: queues register writes and issues one registered one-hot
// write strobe (WRDec_out) with aligned data (Bus_out) per clock.
module wr_dec_sequencer
    import wr_seq_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                   Clock,
    input  logic                   Reset,
    wr_dec_sequencer_if.slave      req_if,
    input  logic                   hold,
    output logic [NUM_REGS-1:0]    WRDec_out,
    output logic [DATA_W-1:0]      Bus_out,
    output logic                   err_out,
    output logic [$clog2(DEPTH):0] pending
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t                  wr_entry, head;
    logic                  accept, addr_ok, push, pop;
    logic                  fifo_full, fifo_empty;
    logic [NUM_REGS-1:0]   wrdec_q, wrdec_d;
    logic [DATA_W-1:0]     bus_q, bus_d;
    logic                  err_q, err_d;

    // Ready comes from registered occupancy only; a same-cycle pop never opens a slot.
    assign req_if.req_ready = !fifo_full;
    assign accept  = req_if.req_valid && !fifo_full;
    assign addr_ok = ({1'b0, req_if.req_addr} < (ADDR_W+1)'(NUM_REGS));
    assign push    = accept && addr_ok;
    assign pop     = !hold && !fifo_empty;

    assign wr_entry.addr = req_if.req_addr;
    assign wr_entry.data = req_if.req_data;

    wr_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pending)
    );

    // Each decoder bit is an independent address match, so the bus is one-hot or zero.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        assign wrdec_d[gi] = pop && (head.addr == ADDR_W'(gi));
    end

    assign bus_d = pop ? head.data : bus_q;
    assign err_d = accept && !addr_ok;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrdec_q <= '0;
            bus_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            wrdec_q <= wrdec_d;
            bus_q   <= bus_d;
            err_q   <= err_d;
        end
    end

    assign WRDec_out = wrdec_q;
    assign Bus_out   = bus_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_wr_dec_sequencer.sv
// Directed self-checking bench for wr_dec_sequencer: one task per scenario,
// inputs driven 1 time unit after each rising edge, outputs checked at the same point.
module tb_wr_dec_sequencer;
    import wr_seq_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        hold;
    logic [19:0] WRDec_out;
    logic [7:0]  Bus_out;
    logic        err_out;
    logic [2:0]  pending;

    int n_checks = 0;
    int n_fail   = 0;

    wr_dec_sequencer_if bus_if ();

    wr_dec_sequencer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .req_if    (bus_if.slave),
        .hold      (hold),
        .WRDec_out (WRDec_out),
        .Bus_out   (Bus_out),
        .err_out   (err_out),
        .pending   (pending)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    always @(negedge Clock) begin
        if (WRDec_out != 20'd0)
            $display("write reg %0d data 0x%02h (strobe %05h)", $clog2(WRDec_out), Bus_out, WRDec_out);
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic v, input wr_req_t r);
        bus_if.req_valid = v;
        bus_if.req_addr  = r.addr;
        bus_if.req_data  = r.data;
    endtask

    task automatic test_reset();
        Reset = 1'b1; hold = 1'b0;
        drive(1'b0, '{addr: 5'd0, data: 8'h00});
        tick(); tick();
        Reset = 1'b0;
        n_checks++; if (WRDec_out !== 20'd0) begin n_fail++; $display("FAIL reset_wrdec: got %05h required 00000", WRDec_out); end
        n_checks++; if (Bus_out !== 8'h00) begin n_fail++; $display("FAIL reset_bus: got %02h required 00", Bus_out); end
        n_checks++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err_out); end
        n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d required 0", pending); end
        n_checks++; if (bus_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus_if.req_ready); end
    endtask

    task automatic test_single();
        drive(1'b1, '{addr: 5'd15, data: 8'h05});
        tick();
        drive(1'b0, '{addr: 5'd0, data: 8'h00});
        n_checks++; if (WRDec_out !== 20'd0) begin n_fail++; $display("FAIL single_nobypass: got %05h required 00000", WRDec_out); end
        n_checks++; if (pending !== 3'd1) begin n_fail++; $display("FAIL single_pending: got %0d required 1", pending); end
        tick();
        n_checks++; if (WRDec_out !== 20'b0000_1000_0000_0000_0000) begin n_fail++; $display("FAIL single_strobe: got %05h required 08000", WRDec_out); end
        n_checks++; if (Bus_out !== 8'h05) begin n_fail++; $display("FAIL single_data: got %02h required 05", Bus_out); end
        tick();
        n_checks++; if (WRDec_out !== 20'd0) begin n_fail++; $display("FAIL single_clear: got %05h required 00000", WRDec_out); end
        n_checks++; if (Bus_out !== 8'h05) begin n_fail++; $display("FAIL single_bus_hold: got %02h required 05", Bus_out); end
    endtask

    task automatic test_back_to_back();
        wr_req_t     reqs [3];
        logic [19:0] exp;
        reqs[0] = '{addr: 5'd0,  data: 8'hA1};
        reqs[1] = '{addr: 5'd1,  data: 8'hB2};
        reqs[2] = '{addr: 5'd19, data: 8'hC3};
        drive(1'b1, reqs[0]);
        tick();
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) drive(1'b1, reqs[i]);
            else       drive(1'b0, '{addr: 5'd0, data: 8'h00});
            tick();
            exp = 20'd1 << reqs[i-1].addr;
            n_checks++; if (WRDec_out !== exp) begin n_fail++; $display("FAIL b2b_strobe[%0d]: got %05h required %05h", i-1, WRDec_out, exp); end
            n_checks++; if (Bus_out !== reqs[i-1].data) begin n_fail++; $display("FAIL b2b_data[%0d]: got %02h required %02h", i-1, Bus_out, reqs[i-1].data); end
        end
        tick();
        n_checks++; if (WRDec_out !== 20'd0) begin n_fail++; $display("FAIL b2b_idle: got %05h required 00000", WRDec_out); end
    endtask

    task automatic test_hold();
        logic [19:0] exp;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, '{addr: 5'(2 + i), data: 8'(8'h12 + i)});
            n_checks++; if (bus_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b required 1", i, bus_if.req_ready); end
            tick();
            n_checks++; if (WRDec_out !== 20'd0) begin n_fail++; $display("FAIL hold_nostrobe[%0d]: got %05h required 00000", i, WRDec_out); end
            n_checks++; if (pending !== 3'(i + 1)) begin n_fail++; $display("FAIL hold_pending[%0d]: got %0d required %0d", i, pending, i + 1); end
        end
        drive(1'b1, '{addr: 5'd6, data: 8'h16});
        n_checks++; if (bus_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_full_ready: got %b required 0", bus_if.req_ready); end
        tick();
        n_checks++; if (pending !== 3'd4) begin n_fail++; $display("FAIL hold_full_pending: got %0d required 4", pending); end
        n_checks++; if (WRDec_out !== 20'd0) begin n_fail++; $display("FAIL hold_full_nostrobe: got %05h required 00000", WRDec_out); end
        hold = 1'b0;
        tick();
        n_checks++; if (pending !== 3'd3) begin n_fail++; $display("FAIL full_pop_pending: got %0d required 3", pending); end
        n_checks++; if (bus_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready: got %b required 1", bus_if.req_ready); end
        tick();
        drive(1'b0, '{addr: 5'd0, data: 8'h00});
        n_checks++; if (pending !== 3'd3) begin n_fail++; $display("FAIL fifth_accept_pending: got %0d required 3", pending); end
        tick(); tick(); tick();
        n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL hold_drain_pending: got %0d required 0", pending); end
        exp = 20'd1 << 6;
        n_checks++; if (WRDec_out !== exp || Bus_out !== 8'h16) begin n_fail++; $display("FAIL hold_fifth_last: got %05h/%02h required %05h/16", WRDec_out, Bus_out, exp); end
        tick();
        n_checks++; if (WRDec_out !== 20'd0) begin n_fail++; $display("FAIL hold_drain_idle: got %05h required 00000", WRDec_out); end
    endtask

    // Drain order after a hold: issue slots must follow push order 2,3,4,5,6.
    task automatic test_hold_order();
        logic [19:0] exp;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, '{addr: 5'(2 + i), data: 8'(8'h12 + i)});
            tick();
        end
        drive(1'b1, '{addr: 5'd6, data: 8'h16});
        hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) drive(1'b0, '{addr: 5'd0, data: 8'h00});
            exp = 20'd1 << (2 + i);
            n_checks++; if (WRDec_out !== exp) begin n_fail++; $display("FAIL order_strobe[%0d]: got %05h required %05h", i, WRDec_out, exp); end
            n_checks++; if (Bus_out !== 8'(8'h12 + i)) begin n_fail++; $display("FAIL order_data[%0d]: got %02h required %02h", i, Bus_out, 8'(8'h12 + i)); end
        end
        tick();
    endtask

    task automatic test_invalid();
        logic [4:0] bad [2];
        bad[0] = 5'd20;
        bad[1] = 5'd25;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, '{addr: bad[i], data: 8'hEE});
            n_checks++; if (bus_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL invalid_ready[%0d]: got %b required 1", i, bus_if.req_ready); end
            tick();
            drive(1'b0, '{addr: 5'd0, data: 8'h00});
            n_checks++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL invalid_err[%0d]: got %b required 1", i, err_out); end
            n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL invalid_pending[%0d]: got %0d required 0", i, pending); end
            tick();
            n_checks++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL invalid_err_clear[%0d]: got %b required 0", i, err_out); end
            n_checks++; if (WRDec_out !== 20'd0) begin n_fail++; $display("FAIL invalid_nostrobe[%0d]: got %05h required 00000", i, WRDec_out); end
        end
    endtask

    task automatic test_reset_flush();
        logic [19:0] exp;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, '{addr: 5'(7 + i), data: 8'(8'h40 + i)});
            tick();
        end
        drive(1'b0, '{addr: 5'd0, data: 8'h00});
        hold = 1'b0;
        tick();
        exp = 20'd1 << 7;
        n_checks++; if (WRDec_out !== exp || pending !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got %05h pending %0d required %05h pending 3", WRDec_out, pending, exp); end
        Reset = 1'b1;
        drive(1'b1, '{addr: 5'd3, data: 8'h99});
        tick();
        Reset = 1'b0;
        drive(1'b0, '{addr: 5'd0, data: 8'h00});
        n_checks++; if (WRDec_out !== 20'd0) begin n_fail++; $display("FAIL flush_wrdec: got %05h required 00000", WRDec_out); end
        n_checks++; if (Bus_out !== 8'h00) begin n_fail++; $display("FAIL flush_bus: got %02h required 00", Bus_out); end
        n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL flush_pending: got %0d required 0", pending); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (WRDec_out !== 20'd0 || pending !== 3'd0) begin n_fail++; $display("FAIL flush_stale[%0d]: got %05h pending %0d required 00000 pending 0", i, WRDec_out, pending); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_hold_order();
        test_invalid();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
